// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: N-channel arbiter in front of one memory port.
//
// Each channel presents a request and its fields. One granted channel is forwarded
// combinationally to the memory port. Every accepted transaction pushes the
// granted channel index into an in-order tag FIFO. Every memory response pops the
// FIFO head and is routed to that channel.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin arbitration with a search-start pointer.
//              undefined -> fixed priority (lowest index wins), no pointer register.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   ch_req/we/addr/wdata/wmask   per-channel request inputs (channel i at [i*W +: W])
//   ch_addr_ok                per-channel accept strobe
//   ch_data_ok                per-channel response strobe
//   ch_rdata                  response data broadcast to all channels
//   mem_req/we/addr/wdata/wmask  downstream request outputs
//   mem_addr_ok, mem_data_ok  downstream accept / response inputs
//   mem_rdata                 downstream read data
//   err_unexp                 sticky: response seen with nothing outstanding
module mem_arbiter_nch #(
  parameter int unsigned NCH  = 2,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned OUTS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH-1:0]        ch_we,
  input  logic [NCH*AW-1:0]     ch_addr,
  input  logic [NCH*DW-1:0]     ch_wdata,
  input  logic [NCH*(DW/8)-1:0] ch_wmask,
  output logic [NCH-1:0]        ch_addr_ok,
  output logic [NCH-1:0]        ch_data_ok,
  output logic [DW-1:0]         ch_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic [DW/8-1:0]       mem_wmask,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [DW-1:0]         mem_rdata,
  output logic                  err_unexp
);

  localparam int unsigned MW = DW / 8;
  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PW = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int unsigned CW = $clog2(OUTS + 1);

  // Grant lock: holds the channel whose request is pending acceptance.
  logic          r_lock;
  logic [IW-1:0] r_lock_idx;

  // Tag FIFO of granted channel indices, in acceptance order.
  logic [IW-1:0] r_tag_mem [OUTS];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_err;

`ifdef ARB_RR_EN
  // Index where the next search begins; reset to 0, moves past each accepted channel.
  logic [IW-1:0] r_rr_ptr;
`endif

  logic          w_arb_found;
  logic [IW-1:0] w_arb_idx;
  logic          w_lock_valid;
  logic          w_any;
  logic [IW-1:0] w_gnt_idx;
  logic [NCH-1:0] w_gnt;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [IW-1:0] w_head;

  // Free arbitration among current requests.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
`ifdef ARB_RR_EN
    for (int k = 0; k < int'(NCH); k++) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % int'(NCH);
      if (!w_arb_found && ch_req[idx]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = IW'(idx);
      end
    end
`else
    for (int k = 0; k < int'(NCH); k++) begin
      if (!w_arb_found && ch_req[k]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = IW'(k);
      end
    end
`endif
  end

  // A lock only matters while its channel still requests; if that channel drops
  // its request, arbitration resumes rather than granting an idle channel.
  assign w_lock_valid = r_lock & ch_req[r_lock_idx];
  assign w_gnt_idx    = w_lock_valid ? r_lock_idx : w_arb_idx;
  assign w_any        = w_lock_valid | w_arb_found;

  assign w_full  = (r_cnt == CW'(OUTS));
  assign w_empty = (r_cnt == '0);

  // Fullness is judged at cycle start, so a same-cycle pop never unblocks a grant.
  assign mem_req = w_any & ~w_full & ~rst;
  assign w_push  = mem_req & mem_addr_ok;
  assign w_pop   = mem_data_ok & ~w_empty & ~rst;
  assign w_head  = r_tag_mem[r_rptr];

  always_comb begin
    w_gnt = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      w_gnt[i] = mem_req & (w_gnt_idx == IW'(i));
    end
  end

  assign ch_addr_ok = w_gnt & {NCH{mem_addr_ok}};

  // Zero-latency field mux; all fields are zero when nothing is granted.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (w_gnt[i]) begin
        mem_we    = ch_we[i];
        mem_addr  = ch_addr[i*AW +: AW];
        mem_wdata = ch_wdata[i*DW +: DW];
        mem_wmask = ch_wmask[i*MW +: MW];
      end
    end
  end

  always_comb begin
    ch_data_ok = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      ch_data_ok[i] = w_pop & (w_head == IW'(i));
    end
  end

  assign ch_rdata  = mem_rdata;
  assign err_unexp = r_err;

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      // Lock while a presented request waits; it drops the cycle after acceptance.
      r_lock     <= mem_req & ~mem_addr_ok;
      r_lock_idx <= w_gnt_idx;

      if (w_push) begin
        r_wptr <= (r_wptr == PW'(OUTS - 1)) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(OUTS - 1)) ? '0 : r_rptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase

      if (mem_data_ok && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= (w_gnt_idx == IW'(NCH - 1)) ? '0 : w_gnt_idx + IW'(1);
    end
  end
`endif

  // Tag storage needs no reset: entries are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wptr] <= w_gnt_idx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Testbench for mem_arbiter_nch with default parameters (NCH=2, AW=32, DW=32, OUTS=2).
// Channel 0: write, addr 0x100, wdata 0xD0, mask 0xF. Channel 1: read, addr 0x200,
// wdata 0xD1, mask 0x3. Expected values come from the vector table and the
// hand-written sequences below.
module tb_mem_arbiter_nch;

  logic        clk;
  logic        rst;
  logic [1:0]  ch_req;
  logic [1:0]  ch_we;
  logic [63:0] ch_addr;
  logic [63:0] ch_wdata;
  logic [7:0]  ch_wmask;
  logic [1:0]  ch_addr_ok;
  logic [1:0]  ch_data_ok;
  logic [31:0] ch_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err_unexp;

  int checks;
  int failures;

  mem_arbiter_nch #(
    .NCH  (2),
    .AW   (32),
    .DW   (32),
    .OUTS (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_req      (ch_req),
    .ch_we       (ch_we),
    .ch_addr     (ch_addr),
    .ch_wdata    (ch_wdata),
    .ch_wmask    (ch_wmask),
    .ch_addr_ok  (ch_addr_ok),
    .ch_data_ok  (ch_data_ok),
    .ch_rdata    (ch_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .err_unexp   (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]  req;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        exp_mreq;
    logic [1:0]  exp_aok;
    logic [1:0]  exp_dok;
    logic        exp_err;
    logic [31:0] exp_addr;
  } vec_t;

  localparam int NVEC = 25;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic aok, input logic dok,
                       input logic [31:0] rdata);
    ch_req      = req;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rdata;
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled here,
  // mid-cycle, and the task returns 1 unit after the next rising edge.
  task automatic settle_and_advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    logic        exp_we;
    logic [1:0]  exp_rr;
    string       nm;

    checks   = 0;
    failures = 0;

    // Table columns: req, aok, dok, rdata | mem_req, ch_addr_ok, ch_data_ok, err, mem_addr
    tbl[0]  = '{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
    // Lock: ch0 held across stalls although ch1 joins.
    tbl[1]  = '{2'b01, 1'b0, 1'b0, 32'h0,        1'b1, 2'b00, 2'b00, 1'b0, 32'h100};
    tbl[2]  = '{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 2'b00, 2'b00, 1'b0, 32'h100};
    tbl[3]  = '{2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 2'b00, 2'b00, 1'b0, 32'h100};
    tbl[4]  = '{2'b11, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 2'b00, 1'b0, 32'h100};
    tbl[5]  = '{2'b00, 1'b0, 1'b1, 32'h11,       1'b0, 2'b00, 2'b01, 1'b0, 32'h0};
    // In-order return: ch1 then ch0.
    tbl[6]  = '{2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 2'b10, 2'b00, 1'b0, 32'h200};
    tbl[7]  = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 2'b00, 1'b0, 32'h100};
    tbl[8]  = '{2'b00, 1'b0, 1'b1, 32'hAAAA5555, 1'b0, 2'b00, 2'b10, 1'b0, 32'h0};
    tbl[9]  = '{2'b00, 1'b0, 1'b1, 32'h12345678, 1'b0, 2'b00, 2'b01, 1'b0, 32'h0};
    // Full FIFO blocks the third request, even with a concurrent pop.
    tbl[10] = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 2'b00, 1'b0, 32'h100};
    tbl[11] = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 2'b00, 1'b0, 32'h100};
    tbl[12] = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[13] = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[14] = '{2'b01, 1'b1, 1'b1, 32'h33,       1'b0, 2'b00, 2'b01, 1'b0, 32'h0};
    tbl[15] = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 2'b00, 1'b0, 32'h100};
    tbl[16] = '{2'b00, 1'b0, 1'b1, 32'h44,       1'b0, 2'b00, 2'b01, 1'b0, 32'h0};
    tbl[17] = '{2'b00, 1'b0, 1'b1, 32'h55,       1'b0, 2'b00, 2'b01, 1'b0, 32'h0};
    // Push and pop in the same cycle with the FIFO not full.
    tbl[18] = '{2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 2'b10, 2'b00, 1'b0, 32'h200};
    tbl[19] = '{2'b01, 1'b1, 1'b1, 32'h66,       1'b1, 2'b01, 2'b10, 1'b0, 32'h100};
    tbl[20] = '{2'b00, 1'b0, 1'b1, 32'h77,       1'b0, 2'b00, 2'b01, 1'b0, 32'h0};
    // Unexpected response: ignored, sticky error from the next cycle on.
    tbl[21] = '{2'b00, 1'b0, 1'b1, 32'h88,       1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[22] = '{2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 1'b1, 32'h0};
    tbl[23] = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01, 2'b00, 1'b1, 32'h100};
    tbl[24] = '{2'b00, 1'b0, 1'b1, 32'h99,       1'b0, 2'b00, 2'b01, 1'b1, 32'h0};

    ch_we    = 2'b01;
    ch_addr  = {32'h200, 32'h100};
    ch_wdata = {32'hD1, 32'hD0};
    ch_wmask = {4'h3, 4'hF};
    rst      = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      drive(tbl[v].req, tbl[v].aok, tbl[v].dok, tbl[v].rdata);
      #3;
      exp_we    = (tbl[v].exp_addr == 32'h100);
      exp_wdata = (tbl[v].exp_addr == 32'h100) ? 32'hD0 :
                  (tbl[v].exp_addr == 32'h200) ? 32'hD1 : 32'h0;
      exp_wmask = (tbl[v].exp_addr == 32'h100) ? 4'hF :
                  (tbl[v].exp_addr == 32'h200) ? 4'h3 : 4'h0;
      nm = $sformatf("vec%0d", v);
      chk({nm, " mem_req"},    64'(mem_req),    64'(tbl[v].exp_mreq));
      chk({nm, " ch_addr_ok"}, 64'(ch_addr_ok), 64'(tbl[v].exp_aok));
      chk({nm, " ch_data_ok"}, 64'(ch_data_ok), 64'(tbl[v].exp_dok));
      chk({nm, " err_unexp"},  64'(err_unexp),  64'(tbl[v].exp_err));
      chk({nm, " mem_addr"},   64'(mem_addr),   64'(tbl[v].exp_addr));
      chk({nm, " mem_we"},     64'(mem_we),     64'(exp_we));
      chk({nm, " mem_wdata"},  64'(mem_wdata),  64'(exp_wdata));
      chk({nm, " mem_wmask"},  64'(mem_wmask),  64'(exp_wmask));
      if (tbl[v].exp_dok != 2'b00) begin
        chk({nm, " ch_rdata"}, 64'(ch_rdata), 64'(tbl[v].rdata));
      end
      settle_and_advance();
    end

    // Reset forces outputs low while active and clears the sticky error.
    rst = 1'b1;
    drive(2'b11, 1'b1, 1'b1, 32'h0);
    #3;
    chk("rst mem_req",    64'(mem_req),    64'(0));
    chk("rst ch_addr_ok", 64'(ch_addr_ok), 64'(0));
    chk("rst ch_data_ok", 64'(ch_data_ok), 64'(0));
    settle_and_advance();
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    #3;
    chk("post-rst err_unexp", 64'(err_unexp), 64'(0));
    settle_and_advance();

    // A tag in flight at reset is discarded; its late response is unexpected.
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    #3;
    chk("inflight accept", 64'(ch_addr_ok), 64'(2'b01));
    settle_and_advance();
    rst = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    settle_and_advance();
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 32'hBEEF);
    #3;
    chk("late resp ch_data_ok", 64'(ch_data_ok), 64'(0));
    settle_and_advance();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    #3;
    chk("late resp err_unexp", 64'(err_unexp), 64'(1));
    settle_and_advance();
    rst = 1'b1;
    settle_and_advance();
    rst = 1'b0;

    // Both channels requesting with every request accepted; responses keep the
    // FIFO from filling. Round-robin alternates, fixed priority always picks ch0.
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, (i > 0), 32'h0);
`ifdef ARB_RR_EN
      exp_rr = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_rr = 2'b01;
`endif
      #3;
      chk($sformatf("arb cycle%0d ch_addr_ok", i), 64'(ch_addr_ok), 64'(exp_rr));
      settle_and_advance();
    end
    drive(2'b00, 1'b0, 1'b1, 32'h0);
    #3;
    chk("arb drain ch_data_ok", 64'(ch_data_ok), 64'(exp_rr));
    settle_and_advance();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    #3;
    chk("arb final err_unexp", 64'(err_unexp), 64'(0));
    settle_and_advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
